// File: rtl/wb_chk_pkg.sv
// ============================================================================
// Module : wb_chk_pkg
// Brief  : Shared constants for the Wishbone initiator protocol checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_chk_pkg;

  localparam int VIOL_WIDTH = 7;

  localparam int VIOL_UNSOL = 0;
  localparam int VIOL_MULTI = 1;
  localparam int VIOL_OVFL  = 2;
  localparam int VIOL_STBNC = 3;
  localparam int VIOL_ABORT = 4;
  localparam int VIOL_TMO   = 5;
  localparam int VIOL_STAB  = 6;

  typedef logic [VIOL_WIDTH-1:0] viol_t;

endpackage : wb_chk_pkg

`default_nettype wire

// File: rtl/wb_itr_chk.sv
// ============================================================================
// Module : wb_itr_chk
// Brief  : Passive Wishbone pipelined-initiator checker with sticky flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_itr_chk
  import wb_chk_pkg::*;
#(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGWD_WIDTH = 1,
  parameter int MAX_OUT    = 4,
  parameter int TIMEOUT    = 16,
  localparam int CW        = $clog2(MAX_OUT + 1)
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sync_rst_i,
  input  logic                  clr_i,
  input  logic                  itr_cyc_i,
  input  logic                  itr_stb_i,
  input  logic                  itr_we_i,
  input  logic [SEL_WIDTH-1:0]  itr_sel_i,
  input  logic [ADR_WIDTH-1:0]  itr_adr_i,
  input  logic [DAT_WIDTH-1:0]  itr_dat_i,
  input  logic [TGA_WIDTH-1:0]  itr_tga_i,
  input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
  input  logic                  itr_ack_o,
  input  logic                  itr_err_o,
  input  logic                  itr_rty_o,
  input  logic                  itr_stall_o,
  output logic [CW-1:0]         outstanding_o,
  output logic                  busy_o,
  output logic [VIOL_WIDTH-1:0] viol_o,
  output logic                  irq_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = 1 + SEL_WIDTH + ADR_WIDTH + DAT_WIDTH + TGA_WIDTH + TGWD_WIDTH;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_nxt;
  viol_t         r_viol;
  viol_t         w_new;
  viol_t         w_viol_nxt;
  logic          r_irq;
  logic          r_prev_cyc;
  logic          r_prev_stall;
  logic          r_rst_mask;
  logic [FW-1:0] r_cap;
  logic [FW-1:0] w_fields;
  logic          w_req;
  logic          w_term;
  logic          w_multi;
  logic          w_cnt_zero;
  logic          w_cnt_full;

  assign w_fields   = {itr_we_i, itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgd_i};
  assign w_req      = itr_cyc_i & itr_stb_i & ~itr_stall_o;
  assign w_term     = itr_ack_o | itr_err_o | itr_rty_o;
  assign w_multi    = (itr_ack_o & itr_err_o) | (itr_ack_o & itr_rty_o) | (itr_err_o & itr_rty_o);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_full = (r_cnt == CW'(MAX_OUT));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!itr_cyc_i) begin
      w_cnt_nxt = '0;
    end else if (w_req && !w_term && !w_cnt_full) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (w_term && !w_req && !w_cnt_zero) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_tmo_nxt = r_tmo;
    if (w_cnt_zero || w_term) begin
      w_tmo_nxt = '0;
    end else if (r_tmo != TW'(TIMEOUT)) begin
      w_tmo_nxt = r_tmo + 1'b1;
    end
  end

  always_comb begin
    w_new             = '0;
    w_new[VIOL_UNSOL] = w_term & w_cnt_zero;
    w_new[VIOL_MULTI] = w_multi;
    w_new[VIOL_OVFL]  = w_req & w_cnt_full & ~w_term;
    w_new[VIOL_STBNC] = itr_stb_i & ~itr_cyc_i;
    w_new[VIOL_ABORT] = r_prev_cyc & ~itr_cyc_i & ~w_cnt_zero;
    // Only the transition into saturation flags, so one stalled episode reports once.
    w_new[VIOL_TMO]   = (w_tmo_nxt == TW'(TIMEOUT)) & (r_tmo != TW'(TIMEOUT));
    w_new[VIOL_STAB]  = r_prev_stall & itr_cyc_i & itr_stb_i & (w_fields != r_cap);
    // Terminations left over from a transfer cut short by reset are not violations.
    if (r_rst_mask) begin
      w_new = '0;
    end
    w_viol_nxt = (clr_i ? '0 : r_viol) | w_new;
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      r_cnt        <= '0;
      r_tmo        <= '0;
      r_viol       <= '0;
      r_irq        <= 1'b0;
      r_prev_cyc   <= 1'b0;
      r_prev_stall <= 1'b0;
      r_rst_mask   <= 1'b1;
      r_cap        <= '0;
    end else if (sync_rst_i) begin
      r_cnt        <= '0;
      r_tmo        <= '0;
      r_viol       <= '0;
      r_irq        <= 1'b0;
      r_prev_cyc   <= 1'b0;
      r_prev_stall <= 1'b0;
      r_rst_mask   <= 1'b1;
      r_cap        <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_tmo        <= w_tmo_nxt;
      r_viol       <= w_viol_nxt;
      r_irq        <= |w_viol_nxt;
      r_prev_cyc   <= itr_cyc_i;
      r_prev_stall <= itr_cyc_i & itr_stb_i & itr_stall_o;
      r_rst_mask   <= 1'b0;
      if (itr_cyc_i && itr_stb_i) begin
        r_cap <= w_fields;
      end
    end
  end

  assign outstanding_o = r_cnt;
  assign busy_o        = ~w_cnt_zero;
  assign viol_o        = r_viol;
  assign irq_o         = r_irq;

endmodule : wb_itr_chk

`default_nettype wire

// File: doc/wb_itr_chk.md
WB_ITR_CHK -- requirements
Module: wb_itr_chk

Interface
REQ-001 Parameter ADR_WIDTH, 16, address bus width.
REQ-002 Parameter DAT_WIDTH, 16, write data bus width.
REQ-003 Parameter SEL_WIDTH, 2, data select width.
REQ-004 Parameter TGA_WIDTH, 1, address tag width.
REQ-005 Parameter TGWD_WIDTH, 1, write data tag width.
REQ-006 Parameter MAX_OUT, 4, maximum outstanding requests (>=1); CW = ceil(log2(MAX_OUT+1)).
REQ-007 Parameter TIMEOUT, 16, cycles without termination before timeout (>=2).
REQ-008 clk_i  in  1  module clock; reset async_rst_i, asynchronous, active-high; clock clk_i.
REQ-009 async_rst_i  in  1  asynchronous reset, active-high.
REQ-010 sync_rst_i  in  1  synchronous reset, active-high.
REQ-011 clr_i  in  1  clears sticky violation flags.
REQ-012 itr_cyc_i  in  1  bus cycle indicator.
REQ-013 itr_stb_i  in  1  access request.
REQ-014 itr_we_i  in  1  write enable.
REQ-015 itr_sel_i  in  SEL_WIDTH  data selects.
REQ-016 itr_adr_i  in  ADR_WIDTH  address.
REQ-017 itr_dat_i  in  DAT_WIDTH  write data.
REQ-018 itr_tga_i  in  TGA_WIDTH  address tags.
REQ-019 itr_tgd_i  in  TGWD_WIDTH  write data tags.
REQ-020 itr_ack_o, itr_err_o, itr_rty_o  in  1 each  terminations (one port each).
REQ-021 itr_stall_o  in  1  target stall.
REQ-022 outstanding_o  out  CW  accepted but unterminated requests.
REQ-023 busy_o  out  1  outstanding_o != 0.
REQ-024 viol_o  out  7  sticky violation flags, bits per REQ-027..033.
REQ-025 irq_o  out  1  OR of viol_o, registered with it.

Function
REQ-026 Definitions: req = cyc & stb & ~stall; term = ack | err | rty; all checks evaluated each rising clk_i edge.
REQ-027 Bit 0 UNSOL: term while outstanding_o == 0 (any cyc value).
REQ-028 Bit 1 MULTI: more than one of ack/err/rty high in the same cycle.
REQ-029 Bit 2 OVFL: req while outstanding_o == MAX_OUT and no term that cycle.
REQ-030 Bit 3 STBNC: stb high while cyc low.
REQ-031 Bit 4 ABORT: cyc falls (1 then 0) while outstanding_o != 0.
REQ-032 Bit 5 TMO: timeout counter reaches TIMEOUT.
REQ-033 Bit 6 STAB: previous cycle cyc&stb&stall, current cycle cyc&stb, and any of we/sel/adr/dat/tga/tgd differs from registered copy.
REQ-034 Counter next: cyc low -> 0; else +1 on req, -1 on term, unchanged on both; saturate at 0 (UNSOL) and MAX_OUT (OVFL).
REQ-035 Timeout counter: cleared when outstanding_o == 0 or term; else increments, saturating at TIMEOUT; TMO set on reaching TIMEOUT, once per stall episode.
REQ-036 Stability capture register loads we/sel/adr/dat/tga/tgd every cycle cyc&stb high.
REQ-037 Flags set one cycle after offending cycle; remain set until clr_i; clr_i with coincident new violation leaves that bit set.
REQ-038 Termination with multiple signals counts as a single termination.

Reset
REQ-039 async_rst_i or sync_rst_i SHALL zero outstanding_o, busy_o, viol_o, irq_o, timeout counter, capture registers and previous-cycle cyc/stb/stall.
REQ-040 Reset mid-transfer SHALL discard outstanding count with no violation flagged in the first cycle after reset.

Structure
REQ-041 Package wb_chk_pkg SHALL hold violation bit index constants and VIOL_WIDTH = 7.
REQ-042 Single module; no sub-module required.

Verification (MAX_OUT=4, TIMEOUT=16)
REQ-043 3 reqs back-to-back, 3 acks one per cycle -> outstanding_o 1,2,3,2,1,0; viol_o stays 0.
REQ-044 req and ack same cycle at outstanding_o=2 -> stays 2; 5th req at 4 with no term -> viol_o[2]=1, count 4.
REQ-045 ack+err together at outstanding_o=1 -> viol_o[1]=1, count 0; further ack -> viol_o[0]=1.
REQ-046 1 req, no term for 16 cycles -> viol_o[5]=1, irq_o=1; clr_i -> viol_o=0 while count holds 1.
REQ-047 stb with stall high, adr 0x1234 -> 0x1235 next cycle -> viol_o[6]=1; cyc dropped at count 2 -> viol_o[4]=1, count 0.
REQ-048 async_rst_i pulsed at count 3 -> all outputs 0 immediately, no flags after release.
